instruction_sequencer: RTL and testbench

//  Program counter and fetch/issue engine ahead of the ISA decoder.

---
 rtl/tpu_isa_pkg.sv | 33 +++
 rtl/instruction_sequencer.sv | 112 +++++++++++
 tb/tb_instruction_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_isa_pkg.sv
// Shared ISA opcode map and sequencer state/error encodings for the TPU front end.
package tpu_isa_pkg;

    localparam logic [2:0] OP_NOP         = 3'b000;
    localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
    localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
    localparam logic [2:0] OP_LOAD_INPUTS = 3'b011;
    localparam logic [2:0] OP_VALID       = 3'b100;
    localparam logic [2:0] OP_STORE       = 3'b101;
    localparam logic [2:0] OP_HALT        = 3'b111;

    // Raw state codes kept as constants so older tooling can decode the register directly.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_CAPTURE  = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_CMP = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_FETCH    = ST_FETCH,
        S_CAPTURE  = ST_CAPTURE,
        S_ISSUE    = ST_ISSUE,
        S_WAIT_CMP = ST_WAIT_CMP,
        S_DONE     = ST_DONE
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OVERRUN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/instruction_sequencer.sv
// Program counter and fetch/issue engine: fetches from sync-read instruction memory and
// offers each instruction to the decoder for one cycle, honouring back-pressure and compute waits.
module instruction_sequencer
    import tpu_isa_pkg::*;
#(
    parameter int INSTR_W    = 16,
    parameter int ADDR_W     = 8,
    parameter int PROG_DEPTH = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               dp_busy,
    input  logic               compute_done,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               running,
    output logic               done,
    output logic [1:0]         err_code
);

    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

    seq_state_t         state;
    logic [INSTR_W-1:0] ir;
    logic [CNT_W-1:0]   wait_cnt;
    logic [2:0]         opcode;
    logic               issue_fire;
    logic               advance;
    logic               timeout_hit;

    assign opcode      = ir[INSTR_W-1 -: 3];
    assign issue_fire  = (state == S_ISSUE) && (opcode != OP_HALT) && !dp_busy;
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

    // Moving to the next instruction: a non-VALID issue, or the end of a compute wait.
    assign advance = (issue_fire && (opcode != OP_VALID))
                   || ((state == S_WAIT_CMP) && compute_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            wait_cnt <= '0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= '0;
                        err_code <= ERR_NONE;
                    end
                end
                S_FETCH:   state <= S_CAPTURE;
                S_CAPTURE: begin
                    ir    <= imem_rdata;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (opcode == OP_HALT) begin
                        state <= S_DONE;
                    end else if (issue_fire && (opcode == OP_VALID)) begin
                        state    <= S_WAIT_CMP;
                        wait_cnt <= '0;
                    end
                end
                S_WAIT_CMP: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (!compute_done && timeout_hit) begin
                        state    <= S_DONE;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // NOTE: with non-blocking assignments the last write in the block wins, so this
            // step overrides the per-state next-state above whenever advance is set.
            if (advance) begin
                if (pc == LAST_PC) begin
                    state    <= S_DONE;
                    err_code <= ERR_OVERRUN;
                end else begin
                    pc    <= pc + 1'b1;
                    state <= S_FETCH;
                end
            end
        end
    end

    assign imem_rd_en  = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr       = issue_fire ? ir : '0;
    assign instr_valid = issue_fire;
    assign running     = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: directed programs with literal timing expectations, then randomized
// programs and input noise compared every cycle against a program-level behavioural model.
module tb_instruction_sequencer;

    localparam int INSTR_W    = 16;
    localparam int ADDR_W     = 4;
    localparam int PROG_DEPTH = 12;
    localparam int TIMEOUT    = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               dp_busy = 1'b0;
    logic               compute_done = 1'b0;
    logic               imem_rd_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               running;
    logic               done;
    logic [1:0]         err_code;

    logic [15:0] mem [0:15];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    bit chk_en  = 1'b0;

    int          valid_cyc [$];
    logic [15:0] valid_val [$];
    int          done_cyc  [$];

    // Model: where the program is (m_where: 0 idle, 1 address out, 2 data back,
    // 3 offering to decoder, 4 awaiting compute, 5 finishing), which instruction, error.
    int m_where = 0;
    int m_pc    = 0;
    int m_err   = 0;
    int m_wait  = 0;

    instruction_sequencer #(
        .INSTR_W   (INSTR_W),
        .ADDR_W    (ADDR_W),
        .PROG_DEPTH(PROG_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dp_busy     (dp_busy),
        .compute_done(compute_done),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int q_int(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] q_val(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? {16'h0, q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task model_next_instr();
        if (m_pc == PROG_DEPTH - 1) begin
            m_where = 5;
            m_err   = 1;
        end else begin
            m_pc    = m_pc + 1;
            m_where = 1;
        end
    endtask

    // Compare process: sampled on the falling edge, then the model steps to the next cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [15:0] cur;
            logic [2:0]  op;
            bit          fire;
            cur  = mem[m_pc];
            op   = cur[15:13];
            fire = (m_where == 3) && (op != 3'b111) && !dp_busy;

            check("running",     running,     m_where != 0);
            check("imem_rd_en",  imem_rd_en,  m_where == 1);
            check("pc",          pc,          m_pc);
            check("imem_addr",   imem_addr,   m_pc);
            check("instr_valid", instr_valid, fire);
            check("instr",       instr,       fire ? cur : 16'h0);
            check("done",        done,        m_where == 5);
            check("err_code",    err_code,    m_err);

            if (instr_valid) begin
                valid_cyc.push_back(cyc - t0);
                valid_val.push_back(instr);
            end
            if (done) done_cyc.push_back(cyc - t0);

            if (reset) begin
                m_where = 0; m_pc = 0; m_err = 0; m_wait = 0;
            end else begin
                case (m_where)
                    0: if (start) begin m_where = 1; m_pc = 0; m_err = 0; end
                    1: m_where = 2;
                    2: m_where = 3;
                    3: begin
                        if (op == 3'b111) m_where = 5;
                        else if (!dp_busy) begin
                            if (op == 3'b100) begin m_where = 4; m_wait = 0; end
                            else model_next_instr();
                        end
                    end
                    4: begin
                        if (compute_done) model_next_instr();
                        else if (m_wait == TIMEOUT - 1) begin m_where = 5; m_err = 2; end
                        m_wait = m_wait + 1;
                    end
                    default: m_where = 0;
                endcase
            end
        end
    end

    task automatic fill_halt();
        for (int a = 0; a < 16; a++) mem[a] = 16'hE000;
    endtask

    // Drives one program run; cycle 0 is the start cycle, -1 disables an event.
    task automatic run_prog(input int busy_from, input int busy_to, input int cd1, input int cd2,
                            input int rst_at, input int extra_start, input int ncycles);
        valid_cyc.delete();
        valid_val.delete();
        done_cyc.delete();
        t0 = cyc;
        for (int c = 0; c < ncycles; c++) begin
            start        = (c == 0) || (c == extra_start);
            dp_busy      = (c >= busy_from) && (c <= busy_to);
            compute_done = (c == cd1) || (c == cd2);
            reset        = (c == rst_at);
            tick();
        end
        start = 0; dp_busy = 0; compute_done = 0; reset = 0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [2:0] op;
        op = 3'($urandom_range(0, 6));
        if (op == 3'b110 && $urandom_range(0, 2) == 0) op = 3'b111;
        return {op, 13'($urandom)};
    endfunction

    initial begin
        fill_halt();
        reset = 1;
        repeat (3) tick();
        chk_en = 1;
        check("rst_running", running, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_pc", pc, 0);
        reset = 0;
        tick();

        // Straight-line program ending in HALT.
        fill_halt();
        mem[0] = 16'h2005; mem[1] = 16'h4000; mem[2] = 16'h6000; mem[3] = 16'hE000;
        run_prog(-1, -1, -1, -1, -1, -1, 16);
        check("t1_issues", valid_cyc.size(), 3);
        check("t1_cyc0", q_int(valid_cyc, 0), 3);
        check("t1_cyc1", q_int(valid_cyc, 1), 6);
        check("t1_cyc2", q_int(valid_cyc, 2), 9);
        check("t1_val0", q_val(valid_val, 0), 32'h2005);
        check("t1_val1", q_val(valid_val, 1), 32'h4000);
        check("t1_val2", q_val(valid_val, 2), 32'h6000);
        check("t1_done", q_int(done_cyc, 0), 13);
        check("t1_err", err_code, 0);

        // Back-pressure on cycles 3..6 delays the first issue.
        run_prog(3, 6, -1, -1, -1, -1, 20);
        check("t2_cyc0", q_int(valid_cyc, 0), 7);
        check("t2_cyc1", q_int(valid_cyc, 1), 10);
        check("t2_done", q_int(done_cyc, 0), 17);

        // VALID waits for compute_done; a second pulse lands in FETCH and is ignored.
        fill_halt();
        mem[0] = 16'h8000; mem[1] = 16'hE000;
        run_prog(-1, -1, 8, 9, -1, -1, 16);
        check("t3_issues", valid_cyc.size(), 1);
        check("t3_cyc0", q_int(valid_cyc, 0), 3);
        check("t3_done", q_int(done_cyc, 0), 12);
        check("t3_err", err_code, 0);
        check("t3_pc", pc, 1);

        // No compute_done: timeout after TIMEOUT cycles of waiting.
        mem[1] = 16'h0000;
        run_prog(-1, -1, -1, -1, -1, -1, 16);
        check("t4_done", q_int(done_cyc, 0), 12);
        check("t4_err", err_code, 2);
        check("t4_pc", pc, 0);

        // Program runs off the end of memory without HALT.
        for (int a = 0; a < 16; a++) mem[a] = 16'h4000;
        run_prog(-1, -1, -1, -1, -1, -1, 40);
        check("t5_issues", valid_cyc.size(), PROG_DEPTH);
        check("t5_last", q_int(valid_cyc, PROG_DEPTH - 1), 36);
        check("t5_done", q_int(done_cyc, 0), 37);
        check("t5_err", err_code, 1);
        check("t5_pc", pc, PROG_DEPTH - 1);
        run_prog(-1, -1, -1, -1, -1, -1, 2);
        check("t5_restart_err", err_code, 0);
        check("t5_restart_pc", pc, 0);
        run_prog(-1, -1, -1, -1, -1, -1, 0);
        for (int c = 0; c < 60 && running; c++) tick();

        // Reset while waiting for compute; a stray start is ignored mid-run.
        fill_halt();
        mem[0] = 16'h8000;
        run_prog(-1, -1, -1, -1, 6, 5, 10);
        check("t6_done_pulses", done_cyc.size(), 0);
        check("t6_running", running, 0);
        check("t6_err", err_code, 0);
        check("t6_pc", pc, 0);

        // Randomized programs with back-pressure, compute pulses, stray starts and resets.
        for (int r = 0; r < 150; r++) begin
            bit finished;
            for (int a = 0; a < 16; a++) mem[a] = rand_instr();
            finished = 0;
            start = 1;
            t0 = cyc;
            for (int c = 0; c < 600; c++) begin
                tick();
                start        = ($urandom_range(0, 19) == 0);
                dp_busy      = ($urandom_range(0, 9) < 3);
                compute_done = ($urandom_range(0, 9) < 2);
                reset        = ($urandom_range(0, 399) == 0);
                if (!running) begin
                    finished = 1;
                    break;
                end
            end
            start = 0; dp_busy = 0; compute_done = 0; reset = 0;
            if (!finished) begin
                check("run_budget", 1, 0);
                reset = 1;
                tick();
                reset = 0;
            end
            tick();
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
